// File: rtl/prim_onehot_check_pipe_pkg.sv
// -----------------------------------------------------------------------------
// prim_onehot_check_pipe_pkg
//
// Shared types and constants for the pipelined multi-channel onehot checker.
//   alert_state_e : alert handshake FSM encoding (unused code 2'b11 -> IDLE)
//   ErrCntWidth   : width of the optional error-cycle counter
// -----------------------------------------------------------------------------
package prim_onehot_check_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ACK  = 2'b10
  } alert_state_e;

  localparam int unsigned ErrCntWidth = 16;

endpackage : prim_onehot_check_pipe_pkg

// File: rtl/prim_onehot_check_core.sv
// -----------------------------------------------------------------------------
// prim_onehot_check_core
//
// Combinational single-channel onehot check. The onehot vector is padded to
// 2**AddrWidth leaves and reduced through a binary tree; each tree node carries
// "any bit set" and "more than one bit set" for its subtree.
//
// Ports:
//   oh         in  OneHotWidth  onehot vector
//   addr       in  AddrWidth    expected position of the set bit
//   en         in  1            expected enable
//   oh0_err    out 1            more than one bit set
//   enable_err out 1            (|oh) disagrees with en
//   addr_err   out 1            set bit is not at addr
// -----------------------------------------------------------------------------
module prim_onehot_check_core #(
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned OneHotWidth = 2**AddrWidth,
  parameter bit          AddrCheck   = 1'b1,
  parameter bit          EnableCheck = 1'b1,
  parameter bit          StrictCheck = 1'b1
) (
  input  logic [OneHotWidth-1:0] oh,
  input  logic [AddrWidth-1:0]   addr,
  input  logic                   en,
  output logic                   oh0_err,
  output logic                   enable_err,
  output logic                   addr_err
);

  localparam int unsigned NumLeaves = 2**AddrWidth;

  typedef struct packed {
    logic any;
    logic multi;
  } tree_t;

  // Level-by-level reduction done in place: node i of the next level is
  // written from nodes 2i and 2i+1, which are never read again afterwards.
  function automatic tree_t tree_reduce(input logic [NumLeaves-1:0] leaves);
    logic [NumLeaves-1:0] any_v;
    logic [NumLeaves-1:0] multi_v;
    tree_t                res;
    any_v   = leaves;
    multi_v = '0;
    for (int l = AddrWidth; l > 0; l--) begin
      for (int i = 0; i < (1 << (l - 1)); i++) begin
        multi_v[i] = multi_v[2*i] | multi_v[2*i+1] | (any_v[2*i] & any_v[2*i+1]);
        any_v[i]   = any_v[2*i] | any_v[2*i+1];
      end
    end
    res.any   = any_v[0];
    res.multi = multi_v[0];
    return res;
  endfunction

  logic [NumLeaves-1:0] oh_pad;
  tree_t                tree;

  // Positions beyond OneHotWidth read as zero, so an out-of-range address
  // with any bit set is reported as an address error.
  assign oh_pad = NumLeaves'(oh);
  assign tree   = tree_reduce(oh_pad);

  assign oh0_err = tree.multi;

  assign enable_err = !EnableCheck ? 1'b0 :
                      StrictCheck  ? (tree.any ^ en) :
                                     (~en & tree.any);

  // The address check only makes sense alongside the enable check.
  assign addr_err = (AddrCheck && EnableCheck) ? (tree.any ^ oh_pad[addr]) : 1'b0;

endmodule : prim_onehot_check_core

// File: rtl/prim_onehot_check_pipe.sv
// -----------------------------------------------------------------------------
// prim_onehot_check_pipe
//
// Checks NumChan onehot/address/enable tuples per cycle, pipes the per-channel
// error PipeStages cycles, filters it through a consecutive-error threshold,
// latches fatal channels and raises a four-phase alert request.
//
// Optional build macro: PRIM_ONEHOT_CHECK_ERR_CNT_EN adds err_cnt_o, a
// saturating count of cycles in which any err_o bit is set.
//
// Ports:
//   clk_i        in  1                      clock
//   rst_i        in  1                      synchronous active-high reset
//   valid_i      in  NumChan                per-channel qualifier
//   oh_i         in  NumChan*OneHotWidth    onehot vectors, channel c at [c*OneHotWidth +: OneHotWidth]
//   addr_i       in  NumChan*AddrWidth      addresses, packed the same way
//   en_i         in  NumChan                expected enables
//   clr_i        in  1                      clears err_chan_o/counters, IDLE only
//   alert_ack_i  in  1                      alert acknowledge
//   err_o        out NumChan                piped raw per-channel error
//   err_chan_o   out NumChan                sticky channels that reached ErrThresh
//   fatal_o      out 1                      sticky fatal, reset only
//   alert_req_o  out 1                      alert request
//   err_cnt_o    out ErrCntWidth            (macro only) error-cycle counter
//
// Handshake: alert_req_o rises on entry to REQ and stays high until
// alert_ack_i is seen high; the FSM then waits in ACK with alert_req_o low
// until alert_ack_i drops, and only then returns to IDLE. Events seen while
// busy are remembered in a pending flag and raise one further request.
// -----------------------------------------------------------------------------
module prim_onehot_check_pipe
  import prim_onehot_check_pipe_pkg::*;
#(
  parameter int unsigned NumChan     = 2,
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned OneHotWidth = 2**AddrWidth,
  parameter bit          AddrCheck   = 1'b1,
  parameter bit          EnableCheck = 1'b1,
  parameter bit          StrictCheck = 1'b1,
  parameter int unsigned PipeStages  = 1,
  parameter int unsigned ErrThresh   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChan-1:0]             valid_i,
  input  logic [NumChan*OneHotWidth-1:0] oh_i,
  input  logic [NumChan*AddrWidth-1:0]   addr_i,
  input  logic [NumChan-1:0]             en_i,
  input  logic                           clr_i,
  input  logic                           alert_ack_i,
  output logic [NumChan-1:0]             err_o,
  output logic [NumChan-1:0]             err_chan_o,
  output logic                           fatal_o,
  output logic                           alert_req_o
`ifdef PRIM_ONEHOT_CHECK_ERR_CNT_EN
  ,
  output logic [ErrCntWidth-1:0]         err_cnt_o
`endif
);

  localparam int unsigned CntWidth = $clog2(ErrThresh + 1);
  localparam logic [CntWidth-1:0] CntMax   = CntWidth'(ErrThresh);
  localparam logic [CntWidth-1:0] CntMaxM1 = CntWidth'(ErrThresh - 1);

  // ---------------------------------------------------------------------------
  // Per-channel combinational check
  // ---------------------------------------------------------------------------
  logic [NumChan-1:0] raw;

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    logic oh0_err;
    logic enable_err;
    logic addr_err;

    prim_onehot_check_core #(
      .AddrWidth   (AddrWidth),
      .OneHotWidth (OneHotWidth),
      .AddrCheck   (AddrCheck),
      .EnableCheck (EnableCheck),
      .StrictCheck (StrictCheck)
    ) u_core (
      .oh         (oh_i[c*OneHotWidth +: OneHotWidth]),
      .addr       (addr_i[c*AddrWidth +: AddrWidth]),
      .en         (en_i[c]),
      .oh0_err    (oh0_err),
      .enable_err (enable_err),
      .addr_err   (addr_err)
    );

    assign raw[c] = valid_i[c] & (oh0_err | enable_err | addr_err);
  end

  // ---------------------------------------------------------------------------
  // Error / valid pipeline
  // ---------------------------------------------------------------------------
  logic [NumChan-1:0] err_p;
  logic [NumChan-1:0] v_p;

  if (PipeStages == 0) begin : g_nopipe
    assign err_p = raw;
    assign v_p   = valid_i;
  end else begin : g_pipe
    logic [NumChan-1:0] err_q [PipeStages];
    logic [NumChan-1:0] v_q   [PipeStages];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < PipeStages; i++) begin
          err_q[i] <= '0;
          v_q[i]   <= '0;
        end
      end else begin
        err_q[0] <= raw;
        v_q[0]   <= valid_i;
        for (int i = 1; i < PipeStages; i++) begin
          err_q[i] <= err_q[i-1];
          v_q[i]   <= v_q[i-1];
        end
      end
    end

    assign err_p = err_q[PipeStages-1];
    assign v_p   = v_q[PipeStages-1];
  end

  assign err_o = err_p;

  // ---------------------------------------------------------------------------
  // Threshold counters and fatal events
  // ---------------------------------------------------------------------------
  alert_state_e state_q, state_d;
  logic         pending_q, pending_d;

  logic [NumChan-1:0][CntWidth-1:0] cnt_q;
  logic [NumChan-1:0]               ev;
  logic                             any_ev;
  logic                             clr_ok;

  assign clr_ok = clr_i & (state_q == IDLE);

  // An event fires only on the step from ErrThresh-1 to ErrThresh, so a
  // counter sitting at saturation does not re-trigger.
  always_comb begin
    ev = '0;
    for (int c = 0; c < NumChan; c++) begin
      ev[c] = v_p[c] & err_p[c] & (cnt_q[c] == CntMaxM1);
    end
  end

  assign any_ev = |ev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < NumChan; c++) begin
        if (clr_ok) begin
          cnt_q[c] <= '0;
        end else if (v_p[c] && err_p[c]) begin
          if (cnt_q[c] != CntMax) begin
            cnt_q[c] <= cnt_q[c] + 1'b1;
          end
        end else if (v_p[c]) begin
          cnt_q[c] <= '0;
        end
      end
    end
  end

  // Sticky records; a new event wins over a coincident clear.
  logic [NumChan-1:0] err_chan_q;
  logic               fatal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_chan_q <= '0;
      fatal_q    <= 1'b0;
    end else begin
      err_chan_q <= clr_ok ? ev : (err_chan_q | ev);
      fatal_q    <= fatal_q | any_ev;
    end
  end

  assign err_chan_o = err_chan_q;
  assign fatal_o    = fatal_q;

  // ---------------------------------------------------------------------------
  // Alert handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (any_ev || pending_q) begin
          state_d   = REQ;
          pending_d = 1'b0;
        end
      end
      REQ: begin
        if (any_ev) pending_d = 1'b1;
        if (alert_ack_i) state_d = ACK;
      end
      ACK: begin
        if (any_ev) pending_d = 1'b1;
        if (!alert_ack_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign alert_req_o = (state_q == REQ);

  // ---------------------------------------------------------------------------
  // Optional error-cycle counter
  // ---------------------------------------------------------------------------
`ifdef PRIM_ONEHOT_CHECK_ERR_CNT_EN
  logic [ErrCntWidth-1:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (clr_ok) begin
      err_cnt_q <= '0;
    end else if ((|err_p) && (err_cnt_q != {ErrCntWidth{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule : prim_onehot_check_pipe

// File: tb/tb_prim_onehot_check_pipe.sv
// -----------------------------------------------------------------------------
// tb_prim_onehot_check_pipe
//
// Three instances share one clock and reset:
//   dut_a : strict, PipeStages=1, ErrThresh=1 (vector table, handshake, clear)
//   dut_b : strict, PipeStages=1, ErrThresh=3 (threshold filtering)
//   dut_c : non-strict, PipeStages=0, driven with dut_a's inputs
// -----------------------------------------------------------------------------
module tb_prim_onehot_check_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]  a_valid, a_en;
  logic [15:0] a_oh;
  logic [5:0]  a_addr;
  logic        a_clr, a_ack;
  logic [1:0]  a_err, a_err_chan;
  logic        a_fatal, a_req;

  logic [1:0]  b_valid, b_en;
  logic [15:0] b_oh;
  logic [5:0]  b_addr;
  logic        b_clr, b_ack;
  logic [1:0]  b_err, b_err_chan;
  logic        b_fatal, b_req;

  logic [1:0]  c_err, c_err_chan;
  logic        c_fatal, c_req;

`ifdef PRIM_ONEHOT_CHECK_ERR_CNT_EN
  logic [15:0] a_err_cnt, b_err_cnt, c_err_cnt;
`endif

  prim_onehot_check_pipe #(
    .NumChan(2), .AddrWidth(3), .OneHotWidth(8), .StrictCheck(1'b1),
    .PipeStages(1), .ErrThresh(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .oh_i(a_oh), .addr_i(a_addr),
    .en_i(a_en), .clr_i(a_clr), .alert_ack_i(a_ack), .err_o(a_err),
    .err_chan_o(a_err_chan), .fatal_o(a_fatal), .alert_req_o(a_req)
`ifdef PRIM_ONEHOT_CHECK_ERR_CNT_EN
    , .err_cnt_o(a_err_cnt)
`endif
  );

  prim_onehot_check_pipe #(
    .NumChan(2), .AddrWidth(3), .OneHotWidth(8), .StrictCheck(1'b1),
    .PipeStages(1), .ErrThresh(3)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .oh_i(b_oh), .addr_i(b_addr),
    .en_i(b_en), .clr_i(b_clr), .alert_ack_i(b_ack), .err_o(b_err),
    .err_chan_o(b_err_chan), .fatal_o(b_fatal), .alert_req_o(b_req)
`ifdef PRIM_ONEHOT_CHECK_ERR_CNT_EN
    , .err_cnt_o(b_err_cnt)
`endif
  );

  prim_onehot_check_pipe #(
    .NumChan(2), .AddrWidth(3), .OneHotWidth(8), .StrictCheck(1'b0),
    .PipeStages(0), .ErrThresh(1)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .oh_i(a_oh), .addr_i(a_addr),
    .en_i(a_en), .clr_i(a_clr), .alert_ack_i(a_ack), .err_o(c_err),
    .err_chan_o(c_err_chan), .fatal_o(c_fatal), .alert_req_o(c_req)
`ifdef PRIM_ONEHOT_CHECK_ERR_CNT_EN
    , .err_cnt_o(c_err_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel 0 and channel 1 of dut_a, one call per cycle's stimulus.
  task automatic drive_a(input logic [7:0] oh1, input logic [2:0] ad1, input logic e1, input logic v1,
                         input logic [7:0] oh0, input logic [2:0] ad0, input logic e0, input logic v0);
    a_oh    = {oh1, oh0};
    a_addr  = {ad1, ad0};
    a_en    = {e1, e0};
    a_valid = {v1, v0};
  endtask

  // dut_b channel 0 only: err=1 drives oh=0 with en=1 (strict error),
  // err=0 drives a clean onehot at address 2.
  task automatic b_cycle(input logic v, input logic err);
    b_valid = {1'b0, v};
    b_oh    = err ? 16'h0000 : 16'h0004;
    tick();
  endtask

  typedef struct {
    logic [15:0] oh;
    logic [5:0]  addr;
    logic [1:0]  en;
    logic [1:0]  valid;
    logic [1:0]  exp_strict;
    logic [1:0]  exp_loose;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{oh: {8'h80, 8'h04}, addr: {3'd7, 3'd2}, en: 2'b11, valid: 2'b11, exp_strict: 2'b00, exp_loose: 2'b00};
    vecs[1] = '{oh: {8'h10, 8'h06}, addr: {3'd3, 3'd2}, en: 2'b11, valid: 2'b11, exp_strict: 2'b11, exp_loose: 2'b11};
    vecs[2] = '{oh: {8'h01, 8'h00}, addr: {3'd0, 3'd0}, en: 2'b01, valid: 2'b11, exp_strict: 2'b11, exp_loose: 2'b10};
    vecs[3] = '{oh: {8'h00, 8'hFF}, addr: {3'd5, 3'd0}, en: 2'b01, valid: 2'b10, exp_strict: 2'b00, exp_loose: 2'b00};
    vecs[4] = '{oh: {8'h20, 8'h01}, addr: {3'd5, 3'd0}, en: 2'b10, valid: 2'b01, exp_strict: 2'b01, exp_loose: 2'b01};
    vecs[5] = '{oh: {8'h40, 8'h40}, addr: {3'd6, 3'd6}, en: 2'b01, valid: 2'b11, exp_strict: 2'b10, exp_loose: 2'b10};

    // Reset block
    rst = 1'b1;
    a_valid = '0; a_oh = '0; a_addr = '0; a_en = '0; a_clr = 1'b0; a_ack = 1'b0;
    b_valid = '0; b_oh = '0; b_addr = {3'd0, 3'd2}; b_en = 2'b01; b_clr = 1'b0; b_ack = 1'b0;
    tick();
    tick();
    check("reset a_err_o",      32'(a_err),      32'h0);
    check("reset a_err_chan_o", 32'(a_err_chan), 32'h0);
    check("reset a_fatal_o",    32'(a_fatal),    32'h0);
    check("reset a_alert_req",  32'(a_req),      32'h0);
    check("reset b_fatal_o",    32'(b_fatal),    32'h0);
    rst = 1'b0;

    // Vector table: dut_c is combinational (check before the edge),
    // dut_a shows the same vector one edge later.
    for (int i = 0; i < 6; i++) begin
      a_oh = vecs[i].oh; a_addr = vecs[i].addr; a_en = vecs[i].en; a_valid = vecs[i].valid;
      #1;
      check($sformatf("vec%0d loose err_o", i), 32'(c_err), 32'(vecs[i].exp_loose));
      tick();
      check($sformatf("vec%0d strict err_o", i), 32'(a_err), 32'(vecs[i].exp_strict));
    end

    // Clean reset before the handshake sequence
    a_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("re-reset fatal_o", 32'(a_fatal), 32'h0);

    // Clean onehot never errors
    drive_a(8'h00, 3'd0, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b1);
    repeat (3) tick();
    check("clean err_o", 32'(a_err), 32'h0);
    check("clean fatal", 32'(a_fatal), 32'h0);

    // Two bits set on ch0
    drive_a(8'h00, 3'd0, 1'b0, 1'b0, 8'h06, 3'd2, 1'b1, 1'b1);
    tick();
    check("multi err_o", 32'(a_err), 32'h1);
    check("multi err_chan before event", 32'(a_err_chan), 32'h0);
    check("multi req before event", 32'(a_req), 32'h0);
    drive_a(8'h00, 3'd0, 1'b0, 1'b0, 8'h04, 3'd2, 1'b1, 1'b1);
    tick();
    check("event err_chan", 32'(a_err_chan), 32'h1);
    check("event fatal", 32'(a_fatal), 32'h1);
    check("event req", 32'(a_req), 32'h1);

    // Request holds until acknowledged
    repeat (5) tick();
    check("req held without ack", 32'(a_req), 32'h1);
    a_ack = 1'b1;
    tick();
    check("req drops after ack", 32'(a_req), 32'h0);

    // ch1 error while in ACK becomes pending
    drive_a(8'h06, 3'd1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1);
    tick();
    check("ch1 err_o", 32'(a_err), 32'h2);
    drive_a(8'h02, 3'd1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1);
    tick();
    check("ch1 err_chan", 32'(a_err_chan), 32'h3);
    check("no req during ACK", 32'(a_req), 32'h0);
    a_ack = 1'b0;
    tick();
    check("back in IDLE req", 32'(a_req), 32'h0);
    tick();
    check("pending second req", 32'(a_req), 32'h1);

    // clr ignored in REQ
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("clr ignored in REQ", 32'(a_err_chan), 32'h3);

    // Finish handshake, then clear in IDLE
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    tick();
    check("idle after handshake", 32'(a_req), 32'h0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("clr in IDLE err_chan", 32'(a_err_chan), 32'h0);
    check("clr keeps fatal", 32'(a_fatal), 32'h1);

    // Reset during REQ
    drive_a(8'h02, 3'd1, 1'b1, 1'b1, 8'h06, 3'd2, 1'b1, 1'b1);
    tick();
    drive_a(8'h02, 3'd1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1);
    tick();
    check("third req", 32'(a_req), 32'h1);
    check("third err_chan", 32'(a_err_chan), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-REQ reset req", 32'(a_req), 32'h0);
    check("mid-REQ reset fatal", 32'(a_fatal), 32'h0);
    check("mid-REQ reset err_chan", 32'(a_err_chan), 32'h0);
    check("mid-REQ reset err_o", 32'(a_err), 32'h0);

    // Threshold of 3 on dut_b: interrupted runs never reach it
    b_cycle(1'b1, 1'b1); b_cycle(1'b1, 1'b1); b_cycle(1'b1, 1'b0);
    b_cycle(1'b1, 1'b1); b_cycle(1'b1, 1'b1);
    b_cycle(1'b1, 1'b0); b_cycle(1'b1, 1'b0); b_cycle(1'b1, 1'b0);
    check("thresh interrupted fatal", 32'(b_fatal), 32'h0);
    check("thresh interrupted err_chan", 32'(b_err_chan), 32'h0);

    // Invalid gaps hold the count
    b_cycle(1'b1, 1'b1); b_cycle(1'b1, 1'b1);
    b_cycle(1'b0, 1'b0); b_cycle(1'b0, 1'b0);
    b_cycle(1'b1, 1'b1);
    check("thresh before third fatal", 32'(b_fatal), 32'h0);
    b_cycle(1'b1, 1'b0);
    check("thresh reached fatal", 32'(b_fatal), 32'h1);
    check("thresh reached err_chan", 32'(b_err_chan), 32'h1);
    check("thresh reached req", 32'(b_req), 32'h1);

`ifdef PRIM_ONEHOT_CHECK_ERR_CNT_EN
    // Error-cycle counter saturates
    a_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cnt reset", 32'(a_err_cnt), 32'h0);
    drive_a(8'h00, 3'd0, 1'b0, 1'b0, 8'h06, 3'd2, 1'b1, 1'b1);
    repeat (3) tick();
    check("err_cnt early", 32'(a_err_cnt), 32'h2);
    repeat (69997) tick();
    check("err_cnt saturated", 32'(a_err_cnt), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_prim_onehot_check_pipe
